// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : Oversampling UART receiver for 8N1-style frames. The line is
//               resynchronised on every start edge, each bit is sampled at its
//               midpoint, and one parallel word is presented per good frame
//               with a one-cycle valid pulse. A low stop bit produces a
//               one-cycle frame_err pulse instead.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
  parameter int CLK_SPEED     = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMPLING_RATE = 16,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  // Clock cycles per sample strobe; the truncation error is tolerated.
  localparam int DIV  = CLK_SPEED / (BAUD_RATE * SAMPLING_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(SAMPLING_RATE);
  localparam int BC_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  c_HALF_LAST = SC_W'(SAMPLING_RATE / 2 - 1);
  localparam logic [SC_W-1:0]  c_FULL_LAST = SC_W'(SAMPLING_RATE - 1);
  localparam logic [BC_W-1:0]  c_BITS_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t                r_state, w_state_n;
  logic                  r_sync1, r_sync2, r_prev;
  logic [DIV_W-1:0]      r_div, w_div_n, w_div_run;
  logic [SC_W-1:0]       r_scnt, w_scnt_n;
  logic [BC_W-1:0]       r_bcnt, w_bcnt_n;
  logic [DATA_BITS-1:0]  r_shift, w_shift_n;
  logic [DATA_BITS-1:0]  r_data, w_data_n;
  logic                  r_valid, w_valid_n;
  logic                  r_ferr, w_ferr_n;
  logic                  w_fall, w_strobe, w_rx_s;

  // Flops reset to 0, so a line held low through reset never looks like a start edge.
  assign w_rx_s    = r_sync2;
  assign w_fall    = r_prev & ~r_sync2;
  assign w_strobe  = (r_div == c_DIV_LAST);
  assign w_div_run = w_strobe ? '0 : r_div + 1'b1;

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

  // Two-flop synchronizer plus edge-history flop for the asynchronous rx line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_scnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_scnt  <= w_scnt_n;
      r_bcnt  <= w_bcnt_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
    end
  end

  // Next-state and datapath decode; the divider only runs inside a frame.
  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_scnt_n  = r_scnt;
    w_bcnt_n  = r_bcnt;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_n  = '0;
        w_scnt_n = '0;
        if (w_fall) begin
          w_state_n = S_START;
        end
      end
      S_START: begin
        w_div_n = w_div_run;
        if (w_strobe) begin
          if (r_scnt == c_HALF_LAST) begin
            w_scnt_n = '0;
            if (!w_rx_s) begin
              w_state_n = S_DATA;
              w_bcnt_n  = '0;
            end else begin
              // Start bit gone by its midpoint: treat as a glitch.
              w_state_n = S_IDLE;
              w_div_n   = '0;
            end
          end else begin
            w_scnt_n = r_scnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        w_div_n = w_div_run;
        if (w_strobe) begin
          if (r_scnt == c_FULL_LAST) begin
            w_scnt_n  = '0;
            w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bcnt == c_BITS_LAST) begin
              w_state_n = S_STOP;
            end else begin
              w_bcnt_n = r_bcnt + 1'b1;
            end
          end else begin
            w_scnt_n = r_scnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        w_div_n = w_div_run;
        if (w_strobe) begin
          if (r_scnt == c_FULL_LAST) begin
            w_scnt_n = '0;
            w_div_n  = '0;
            if (w_rx_s) begin
              w_data_n  = r_shift;
              w_valid_n = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_ferr_n  = 1'b1;
              w_state_n = S_WAIT_IDLE;
            end
          end else begin
            w_scnt_n = r_scnt + 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Break or stuck-low line: wait for the line to return high.
        w_div_n  = '0;
        w_scnt_n = '0;
        if (w_rx_s) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_div_n   = '0;
        w_scnt_n  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Self-checking bench for uart_rx_oversampled. A serial driver
//               pushes the expected outcome of each frame into a queue; a
//               monitor pops and compares whenever valid or frame_err fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

  // Scaled-down clock/baud so one bit lasts 64 clk (DIV = 4).
  localparam int CLK_SPEED = 1000000;
  localparam int BAUD      = 15625;
  localparam int SR        = 16;
  localparam int DB        = 8;
  localparam int BIT       = CLK_SPEED / BAUD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          ferr;
    logic [DB-1:0] d;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [DB-1:0] last_good = '0;

  uart_rx_oversampled #(
    .CLK_SPEED    (CLK_SPEED),
    .BAUD_RATE    (BAUD),
    .SAMPLING_RATE(SR),
    .DATA_BITS    (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame LSB first; the expected outcome is queued up front.
  task automatic send(input logic [DB-1:0] b, input int per, input logic stop_bit);
    exp_t e;
    if (stop_bit) begin
      e.ferr    = 1'b0;
      e.d       = b;
      last_good = b;
    end else begin
      e.ferr = 1'b1;
      e.d    = last_good;
    end
    q.push_back(e);
    rx = 1'b0;
    wait_clk(per);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      wait_clk(per);
    end
    rx = stop_bit;
    wait_clk(per);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      chk("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid=%b frame_err=%b data=%0h expected no pulse",
                 valid, frame_err, data);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e.ferr});
        chk("pulse_data", {24'd0, data}, {24'd0, mon_e.d});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DB-1:0] b;
    int            per;
    int            t;

    // Reset state
    rx  = 1'b1;
    rst = 1'b1;
    wait_clk(3);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(5);

    // Single nominal frame
    send(8'hA5, BIT, 1'b1);
    wait_clk(2 * BIT);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_drained", q.size(), 32'd0);

    // Back-to-back frames with no extra idle
    send(8'h00, BIT, 1'b1);
    send(8'hFF, BIT, 1'b1);
    wait_clk(BIT);
    chk("t2_drained", q.size(), 32'd0);

    // Random frames, random small drift and gaps
    for (int n = 0; n < 24; n++) begin
      b   = DB'($urandom);
      per = BIT - 1 + int'($urandom_range(0, 2));
      send(b, per, 1'b1);
      wait_clk(int'($urandom_range(0, 20)));
    end
    wait_clk(BIT);
    chk("rand_drained", q.size(), 32'd0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    wait_clk(10);
    rx = 1'b1;
    chk("t3_busy_during", {31'd0, busy}, 32'd1);
    wait_clk(70);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);

    // Frame error followed by a stuck-low line
    send(8'h3C, BIT, 1'b0);
    wait_clk(300);
    chk("t4_busy_stuck", {31'd0, busy}, 32'd1);
    chk("t4_data_held", {24'd0, data}, {24'd0, last_good});
    chk("t4_drained", q.size(), 32'd0);
    rx = 1'b1;
    wait_clk(5);
    chk("t4_busy_release", {31'd0, busy}, 32'd0);
    wait_clk(20);

    // Reset in the middle of the data bits, released with rx low
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      wait_clk(BIT);
    end
    rx = 1'b0;
    wait_clk(BIT / 2);
    rst = 1'b1;
    wait_clk(3);
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    chk("t5_valid_rst", {31'd0, valid}, 32'd0);
    chk("t5_data_rst", {24'd0, data}, 32'd0);
    last_good = '0;
    rst = 1'b0;
    wait_clk(200);
    chk("t5_no_start_low", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_clk(20);
    send(8'h5A, BIT, 1'b1);
    wait_clk(BIT);
    chk("t5_drained", q.size(), 32'd0);

    // Sender drift of roughly -2% and +2%
    send(8'h81, BIT - 1, 1'b1);
    wait_clk(20);
    send(8'h81, BIT + 1, 1'b1);
    wait_clk(BIT);

    t = 0;
    while (q.size() > 0 && t < 2000) begin
      wait_clk(1);
      t++;
    end
    chk("final_drained", q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
